// File: rtl/img_stream_loader.sv
// -----------------------------------------------------------------------------
// img_stream_loader
//
// Upstream feeder for the grayscale conversion stage. Accepts a raster-ordered
// pixel stream over a valid/ready handshake and writes each pixel into the
// image SRAM at its (x,y) address. When the whole frame has been written,
// load_done pulses for one cycle; it drives the converter's new_trans.
//
// Ports
//   clk         clock, rising edge
//   n_rst       asynchronous active-low reset
//   start       begin a frame (sampled only while idle)
//   max_x/max_y last column/row index (inclusive), latched on start
//   in_valid    stream beat valid
//   in_ready    loader can accept a beat
//   in_data     pixel value
//   in_last     source marks final beat of frame
//   x_addr_img  SRAM write column (zero-extended)
//   y_addr_img  SRAM write row (zero-extended)
//   wen_img     SRAM write enable, one cycle per pixel
//   wdat_img    SRAM write data
//   busy        high whenever a frame is in progress
//   load_done   one-cycle pulse once the last pixel write has been issued
//   frame_err   sticky: in_last did not coincide with the final pixel
// -----------------------------------------------------------------------------
module img_stream_loader #(
    parameter int X_MAX       = 200,
    parameter int Y_MAX       = 200,
    parameter int PIXEL_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic [$clog2(X_MAX)-1:0] max_x,
    input  logic [$clog2(Y_MAX)-1:0] max_y,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIXEL_DEPTH-1:0]   in_data,
    input  logic                     in_last,
    output logic [$clog2(X_MAX):0]   x_addr_img,
    output logic [$clog2(Y_MAX):0]   y_addr_img,
    output logic                     wen_img,
    output logic [PIXEL_DEPTH-1:0]   wdat_img,
    output logic                     busy,
    output logic                     load_done,
    output logic                     frame_err
);

    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    state_t                 state_reg;
    logic [XW-1:0]          max_x_reg;
    logic [YW-1:0]          max_y_reg;
    logic [XW-1:0]          cur_x_reg;
    logic [YW-1:0]          cur_y_reg;
    logic                   in_ready_reg;
    logic [XW:0]            x_addr_reg;
    logic [YW:0]            y_addr_reg;
    logic                   wen_reg;
    logic [PIXEL_DEPTH-1:0] wdat_reg;
    logic                   busy_reg;
    logic                   load_done_reg;
    logic                   frame_err_reg;

    logic accept;
    logic at_end;
    logic final_beat;

    // in_ready_reg is high exactly while in LOAD, so it doubles as the
    // "accepting" qualifier for the handshake.
    assign accept     = in_valid && in_ready_reg;
    assign at_end     = (cur_x_reg == max_x_reg) && (cur_y_reg == max_y_reg);
    assign final_beat = at_end || in_last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            max_x_reg     <= '0;
            max_y_reg     <= '0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            in_ready_reg  <= 1'b0;
            x_addr_reg    <= '0;
            y_addr_reg    <= '0;
            wen_reg       <= 1'b0;
            wdat_reg      <= '0;
            busy_reg      <= 1'b0;
            load_done_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            wen_reg       <= 1'b0;
            load_done_reg <= 1'b0;

            // Registered write path: the beat accepted at this edge is
            // presented to the SRAM during the following cycle. Address and
            // data otherwise hold their previous values.
            if (accept) begin
                wen_reg    <= 1'b1;
                x_addr_reg <= {1'b0, cur_x_reg};
                y_addr_reg <= {1'b0, cur_y_reg};
                wdat_reg   <= in_data;
                if (cur_x_reg == max_x_reg) begin
                    cur_x_reg <= '0;
                    cur_y_reg <= cur_y_reg + YW'(1);
                end else begin
                    cur_x_reg <= cur_x_reg + XW'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= LOAD;
                        max_x_reg     <= max_x;
                        max_y_reg     <= max_y;
                        cur_x_reg     <= '0;
                        cur_y_reg     <= '0;
                        frame_err_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept && final_beat) begin
                        state_reg    <= FLUSH;
                        in_ready_reg <= 1'b0;
                        // Flags both an early in_last and a missing one.
                        if (at_end != in_last) begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // The final pixel write is on the SRAM port this cycle;
                    // load_done follows so the converter starts after it.
                    state_reg     <= DONE;
                    load_done_reg <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign x_addr_img = x_addr_reg;
    assign y_addr_img = y_addr_reg;
    assign wen_img    = wen_reg;
    assign wdat_img   = wdat_reg;
    assign busy       = busy_reg;
    assign load_done  = load_done_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_img_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_img_stream_loader
//
// Scoreboard bench for img_stream_loader. The stimulus process computes the
// expected SRAM writes and completion record of each frame from the raster
// rules (index k -> x = k mod width, y = k div width; the frame ends at the
// first beat that is either the last position or flagged in_last) and pushes
// them into a queue. A monitor pops and compares whenever the DUT asserts
// wen_img or load_done.
// -----------------------------------------------------------------------------
module tb_img_stream_loader;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [7:0] max_x;
    logic [7:0] max_y;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [8:0] x_addr_img;
    logic [8:0] y_addr_img;
    logic       wen_img;
    logic [7:0] wdat_img;
    logic       busy;
    logic       load_done;
    logic       frame_err;

    img_stream_loader #(
        .X_MAX      (200),
        .Y_MAX      (200),
        .PIXEL_DEPTH(8)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .max_x     (max_x),
        .max_y     (max_y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .x_addr_img(x_addr_img),
        .y_addr_img(y_addr_img),
        .wen_img   (wen_img),
        .wdat_img  (wdat_img),
        .busy      (busy),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int x;
        int y;
        int d;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   mon_en = 1'b0;
    bit   prev_wen = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every DUT output event consumes one scoreboard entry.
    always @(negedge clk) begin
        if (mon_en && (wen_img || load_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_done) begin
                    check("done_pulse", {31'd0, load_done && !wen_img}, 1);
                    check("done_after_last_write", {31'd0, prev_wen}, 1);
                    check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                end else begin
                    check("wen_without_done", {31'd0, wen_img && !load_done}, 1);
                    check("x_addr", int'(x_addr_img), e.x);
                    check("y_addr", int'(y_addr_img), e.y);
                    check("wdat", int'(wdat_img), e.d);
                end
            end
        end
        prev_wen = wen_img;
    end

    // mode: 0 = in_last on final position, 1 = early in_last at beat early_k,
    //       2 = no in_last. gap: 0 none, -1 alternate cycles, else percent idle.
    // base >= 0 gives data base+k, otherwise random data.
    task automatic run_frame(input int mx, input int my, input int mode,
                             input int early_k, input int gap, input int base,
                             input bit inject_start);
        int n;
        int end_k;
        int dat[$];
        int k;
        int tries;
        int wait_cnt;
        bit accepted;
        exp_t e;

        n     = (mx + 1) * (my + 1);
        end_k = (mode == 1) ? early_k : n - 1;
        for (int i = 0; i < n; i++) begin
            dat.push_back((base >= 0) ? ((base + i) & 255) : int'($urandom_range(0, 255)));
        end
        for (int i = 0; i <= end_k; i++) begin
            e.is_done = 1'b0;
            e.x = i % (mx + 1);
            e.y = i / (mx + 1);
            e.d = dat[i];
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.x = 0;
        e.y = 0;
        e.d = 0;
        e.err = (mode != 0);
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        max_x = 8'(mx);
        max_y = 8'(my);
        @(negedge clk);
        start = 1'b0;
        max_x = 8'($urandom_range(0, 199));
        max_y = 8'($urandom_range(0, 199));
        check("start_busy", {31'd0, busy}, 1);
        check("start_in_ready", {31'd0, in_ready}, 1);
        check("start_clears_err", {31'd0, frame_err}, 0);

        k = 0;
        tries = 0;
        while (k <= end_k && tries < 4000) begin
            if (gap == -1) in_valid = tries[0];
            else           in_valid = (int'($urandom_range(0, 99)) >= gap);
            in_data = 8'(dat[k]);
            in_last = (mode == 0 && k == n - 1) || (mode == 1 && k == early_k);
            start   = inject_start && (k == 1);
            accepted = in_valid && in_ready;
            @(negedge clk);
            tries++;
            if (accepted) k++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        check("beats_accepted_in_budget", {31'd0, k > end_k}, 1);

        wait_cnt = 0;
        while (busy && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("busy_released", {31'd0, busy}, 0);
        check("in_ready_after_frame", {31'd0, in_ready}, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int mx;
        int my;
        int mode;
        int ek;

        n_rst    = 1'b0;
        start    = 1'b0;
        max_x    = 8'd0;
        max_y    = 8'd0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 0);
        check("reset_wen", {31'd0, wen_img}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_load_done", {31'd0, load_done}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        check("reset_addr", int'({x_addr_img, y_addr_img}), 0);
        check("reset_wdat", int'(wdat_img), 0);
        n_rst  = 1'b1;
        mon_en = 1'b1;

        // Directed cases.
        run_frame(2, 1, 0, 0, 0, 10, 1'b0);   // back-to-back 3x2
        run_frame(2, 1, 0, 0, -1, 10, 1'b0);  // alternate-cycle gaps
        run_frame(2, 1, 1, 2, 0, 10, 1'b0);   // in_last on 3rd beat
        run_frame(2, 1, 2, 0, 0, 10, 1'b0);   // no in_last at all
        run_frame(2, 1, 0, 0, 0, 10, 1'b1);   // start pulsed during LOAD

        // Reset in the middle of a frame.
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        max_x = 8'd2;
        max_y = 8'd1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n_rst    = 1'b0;
        #1;
        check("midreset_in_ready", {31'd0, in_ready}, 0);
        check("midreset_wen", {31'd0, wen_img}, 0);
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_load_done", {31'd0, load_done}, 0);
        check("midreset_frame_err", {31'd0, frame_err}, 0);
        check("midreset_addr", int'({x_addr_img, y_addr_img}), 0);
        check("midreset_wdat", int'(wdat_img), 0);
        repeat (2) @(negedge clk);
        n_rst  = 1'b1;
        mon_en = 1'b1;
        run_frame(0, 0, 0, 0, 0, 8'hAB, 1'b0); // 1x1 frame

        // Boundary widths.
        run_frame(199, 0, 0, 0, 0, -1, 1'b0);
        run_frame(0, 199, 0, 0, 10, -1, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            mx   = $urandom_range(0, 5);
            my   = $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            ek   = 0;
            if (mode == 1) begin
                if ((mx + 1) * (my + 1) < 2) mode = 0;
                else ek = $urandom_range(0, (mx + 1) * (my + 1) - 2);
            end
            run_frame(mx, my, mode, ek, $urandom_range(0, 60), -1,
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
